// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Brief    : Shared types and constants for the modulo-N snapshot counter.
// Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

    typedef enum logic {
        SNAP_EMPTY = 1'b0,
        SNAP_FULL  = 1'b1
    } snap_state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage
`default_nettype wire

// File: rtl/count_snap_reg.sv
`default_nettype none
// ============================================================================
// Module   : count_snap_reg
// Brief    : One-entry valid/ready snapshot holder for the counter value.
// Revision : 1.0 - initial release
// ============================================================================
module count_snap_reg
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q,
    input  logic             snap_req,
    input  logic             snap_ready,
    output logic             snap_valid,
    output logic [WIDTH-1:0] snap_data,
    output logic             snap_miss
);

    snap_state_t      r_state;
    snap_state_t      w_state_next;
    logic             w_capture;
    logic             w_miss_next;
    logic [WIDTH-1:0] r_data;
    logic             r_miss;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SNAP_EMPTY;
            r_data  <= '0;
            r_miss  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_miss  <= w_miss_next;
            if (w_capture) begin
                r_data <= q;
            end
        end
    end

    // A full holder with an accepting consumer recycles in place, so a
    // back-to-back request never sees a bubble.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_miss_next  = 1'b0;
        case (r_state)
            SNAP_EMPTY: begin
                if (snap_req) begin
                    w_capture    = 1'b1;
                    w_state_next = SNAP_FULL;
                end
            end
            SNAP_FULL: begin
                if (snap_ready && snap_req) begin
                    w_capture = 1'b1;
                end else if (snap_ready) begin
                    w_state_next = SNAP_EMPTY;
                end else if (snap_req) begin
                    w_miss_next = 1'b1;
                end
            end
            default: begin
                w_state_next = SNAP_EMPTY;
            end
        endcase
    end

    assign snap_valid = (r_state == SNAP_FULL);
    assign snap_data  = r_data;
    assign snap_miss  = r_miss;

endmodule
`default_nettype wire

// File: rtl/counter_mod_snap.sv
`default_nettype none
// ============================================================================
// Module   : counter_mod_snap
// Brief    : Modulo-N up/down counter with load, terminal-count pulse,
//            sticky overflow and a valid/ready snapshot port.
// Revision : 1.0 - initial release
// ============================================================================
module counter_mod_snap
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             ovf,
    input  logic             clr_ovf,
    input  logic             snap_req,
    output logic             snap_valid,
    input  logic             snap_ready,
    output logic [WIDTH-1:0] snap_data,
    output logic             snap_miss
);

    localparam logic [WIDTH-1:0] c_RESET_Q = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             r_ovf;
    logic [WIDTH-1:0] w_q_next;
    logic             w_tc_next;

    // Wrap decisions are pure compares; >= and > also catch a mod_val
    // lowered beneath the current count.
    always_comb begin
        w_q_next  = r_q;
        w_tc_next = 1'b0;
        if (load) begin
            w_q_next = (load_val > mod_val) ? mod_val : load_val;
        end else if (en) begin
            case (up_dn)
                DIR_UP: begin
                    if (r_q >= mod_val) begin
                        w_q_next  = '0;
                        w_tc_next = 1'b1;
                    end else begin
                        w_q_next = r_q + c_ONE;
                    end
                end
                DIR_DN: begin
                    if (r_q == '0) begin
                        w_q_next  = mod_val;
                        w_tc_next = 1'b1;
                    end else if (r_q > mod_val) begin
                        w_q_next = mod_val;
                    end else begin
                        w_q_next = r_q - c_ONE;
                    end
                end
                default: begin
                    w_q_next = r_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q   <= c_RESET_Q;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_q  <= w_q_next;
            r_tc <= w_tc_next;
            if (w_tc_next) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign q   = r_q;
    assign qn  = ~r_q;
    assign tc  = r_tc;
    assign ovf = r_ovf;

    count_snap_reg #(
        .WIDTH (WIDTH)
    ) u_snap (
        .clk        (clk),
        .reset      (reset),
        .q          (r_q),
        .snap_req   (snap_req),
        .snap_ready (snap_ready),
        .snap_valid (snap_valid),
        .snap_data  (snap_data),
        .snap_miss  (snap_miss)
    );

endmodule
`default_nettype wire

// File: tb/tb_counter_mod_snap.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_mod_snap
// Brief    : Directed-vector scoreboard bench for counter_mod_snap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_mod_snap;

    localparam int WIDTH = 4;

    typedef struct {
        int          idx;
        logic [3:0]  q;
        logic        tc;
        logic        ovf;
        logic        sv;
        logic [3:0]  sd;
        logic        sm;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] mod_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             tc;
    logic             ovf;
    logic             clr_ovf;
    logic             snap_req;
    logic             snap_valid;
    logic             snap_ready;
    logic [WIDTH-1:0] snap_data;
    logic             snap_miss;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_push = 0;

    always #5 clk = ~clk;

    counter_mod_snap #(
        .WIDTH     (WIDTH),
        .RESET_VAL (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .up_dn      (up_dn),
        .load       (load),
        .load_val   (load_val),
        .mod_val    (mod_val),
        .q          (q),
        .qn         (qn),
        .tc         (tc),
        .ovf        (ovf),
        .clr_ovf    (clr_ovf),
        .snap_req   (snap_req),
        .snap_valid (snap_valid),
        .snap_ready (snap_ready),
        .snap_data  (snap_data),
        .snap_miss  (snap_miss)
    );

    function automatic void chk(input int idx, input string name,
                                input logic [3:0] act, input logic [3:0] req);
        if (act !== req) begin
            n_miss++;
            $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, req);
        end
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic i_rst, input logic i_en, input logic i_up,
                        input logic i_ld, input logic [3:0] i_lv,
                        input logic [3:0] i_mod, input logic i_clr,
                        input logic i_req, input logic i_rdy,
                        input logic [3:0] e_q, input logic e_tc,
                        input logic e_ovf, input logic e_sv,
                        input logic [3:0] e_sd, input logic e_sm);
        exp_t e;
        @(negedge clk);
        reset      = i_rst;
        en         = i_en;
        up_dn      = i_up;
        load       = i_ld;
        load_val   = i_lv;
        mod_val    = i_mod;
        clr_ovf    = i_clr;
        snap_req   = i_req;
        snap_ready = i_rdy;
        e.idx = n_push;
        e.q   = e_q;
        e.tc  = e_tc;
        e.ovf = e_ovf;
        e.sv  = e_sv;
        e.sd  = e_sd;
        e.sm  = e_sm;
        exp_q.push_back(e);
        n_push++;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            chk(e.idx, "q",          q,                  e.q);
            chk(e.idx, "qn",         qn,                 ~e.q);
            chk(e.idx, "tc",         {3'b0, tc},         {3'b0, e.tc});
            chk(e.idx, "ovf",        {3'b0, ovf},        {3'b0, e.ovf});
            chk(e.idx, "snap_valid", {3'b0, snap_valid}, {3'b0, e.sv});
            chk(e.idx, "snap_data",  snap_data,          e.sd);
            chk(e.idx, "snap_miss",  {3'b0, snap_miss},  {3'b0, e.sm});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        mod_val = 4'd9; clr_ovf = 1'b0; snap_req = 1'b0; snap_ready = 1'b0;

        //    rst en up ld lv    mod   clr rq ry | q     tc ovf sv sd    sm
        step(1, 0, 1, 0, 4'd0, 4'd9, 0, 0, 0,   4'd0, 0, 0, 0, 4'd0, 0);
        // Up count through the wrap at mod_val=9
        for (int i = 1; i <= 9; i++)
            step(0, 1, 1, 0, 4'd0, 4'd9, 0, 0, 0, 4'(i), 0, 0, 0, 4'd0, 0);
        step(0, 1, 1, 0, 4'd0, 4'd9, 0, 0, 0,   4'd0, 1, 1, 0, 4'd0, 0);
        step(0, 1, 1, 0, 4'd0, 4'd9, 0, 0, 0,   4'd1, 0, 1, 0, 4'd0, 0);
        // Load clamp, then down count through the wrap
        step(0, 1, 1, 1, 4'd12, 4'd9, 0, 0, 0,  4'd9, 0, 1, 0, 4'd0, 0);
        for (int i = 8; i >= 0; i--)
            step(0, 1, 0, 0, 4'd0, 4'd9, 0, 0, 0, 4'(i), 0, 1, 0, 4'd0, 0);
        step(0, 1, 0, 0, 4'd0, 4'd9, 0, 0, 0,   4'd9, 1, 1, 0, 4'd0, 0);
        step(0, 1, 0, 0, 4'd0, 4'd9, 0, 0, 0,   4'd8, 0, 1, 0, 4'd0, 0);
        step(0, 0, 0, 0, 4'd0, 4'd9, 1, 0, 0,   4'd8, 0, 0, 0, 4'd0, 0);
        step(0, 0, 0, 0, 4'd0, 4'd9, 0, 0, 0,   4'd8, 0, 0, 0, 4'd0, 0);
        // mod_val lowered beneath q, then mod_val=0
        step(0, 0, 1, 1, 4'd7, 4'd9, 0, 0, 0,   4'd7, 0, 0, 0, 4'd0, 0);
        step(0, 1, 1, 0, 4'd0, 4'd4, 0, 0, 0,   4'd0, 1, 1, 0, 4'd0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 1, 1, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 1, 0, 4'd0, 0);
        step(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0,   4'd0, 1, 1, 0, 4'd0, 0);
        step(0, 1, 1, 1, 4'd5, 4'd0, 0, 0, 0,   4'd0, 0, 1, 0, 4'd0, 0);
        step(0, 0, 1, 1, 4'd7, 4'd9, 0, 0, 0,   4'd7, 0, 1, 0, 4'd0, 0);
        step(0, 1, 0, 0, 4'd0, 4'd4, 0, 0, 0,   4'd4, 0, 1, 0, 4'd0, 0);
        step(0, 0, 1, 0, 4'd0, 4'd9, 1, 0, 0,   4'd4, 0, 0, 0, 4'd0, 0);
        // Snapshot back-pressure and miss
        step(0, 0, 1, 1, 4'd3, 4'd9, 0, 0, 0,   4'd3, 0, 0, 0, 4'd0, 0);
        step(0, 1, 1, 0, 4'd0, 4'd9, 0, 1, 0,   4'd4, 0, 0, 1, 4'd3, 0);
        step(0, 1, 1, 0, 4'd0, 4'd9, 0, 0, 0,   4'd5, 0, 0, 1, 4'd3, 0);
        step(0, 0, 1, 0, 4'd0, 4'd9, 0, 1, 0,   4'd5, 0, 0, 1, 4'd3, 1);
        step(0, 0, 1, 0, 4'd0, 4'd9, 0, 0, 0,   4'd5, 0, 0, 1, 4'd3, 0);
        step(0, 0, 1, 0, 4'd0, 4'd9, 0, 0, 1,   4'd5, 0, 0, 0, 4'd3, 0);
        // Simultaneous accept and request while full
        step(0, 0, 1, 1, 4'd2, 4'd9, 0, 0, 1,   4'd2, 0, 0, 0, 4'd3, 0);
        step(0, 1, 1, 0, 4'd0, 4'd9, 0, 1, 0,   4'd3, 0, 0, 1, 4'd2, 0);
        step(0, 1, 1, 0, 4'd0, 4'd9, 0, 0, 0,   4'd4, 0, 0, 1, 4'd2, 0);
        step(0, 1, 1, 0, 4'd0, 4'd9, 0, 0, 0,   4'd5, 0, 0, 1, 4'd2, 0);
        step(0, 1, 1, 0, 4'd0, 4'd9, 0, 0, 0,   4'd6, 0, 0, 1, 4'd2, 0);
        step(0, 0, 1, 0, 4'd0, 4'd9, 0, 1, 1,   4'd6, 0, 0, 1, 4'd6, 0);
        step(0, 0, 1, 0, 4'd0, 4'd9, 0, 0, 1,   4'd6, 0, 0, 0, 4'd6, 0);
        // Set beats clear on ovf
        step(0, 1, 1, 0, 4'd0, 4'd6, 0, 0, 0,   4'd0, 1, 1, 0, 4'd6, 0);
        step(0, 0, 1, 1, 4'd6, 4'd6, 0, 0, 0,   4'd6, 0, 1, 0, 4'd6, 0);
        step(0, 1, 1, 0, 4'd0, 4'd6, 1, 0, 0,   4'd0, 1, 1, 0, 4'd6, 0);
        step(0, 0, 1, 0, 4'd0, 4'd6, 0, 0, 0,   4'd0, 0, 1, 0, 4'd6, 0);
        // Reset while full, mid-count and with a miss pending
        step(0, 1, 1, 0, 4'd0, 4'd9, 0, 0, 0,   4'd1, 0, 1, 0, 4'd6, 0);
        step(0, 1, 1, 0, 4'd0, 4'd9, 0, 1, 0,   4'd2, 0, 1, 1, 4'd1, 0);
        step(1, 1, 1, 0, 4'd0, 4'd9, 0, 1, 0,   4'd0, 0, 0, 0, 4'd0, 0);
        step(0, 0, 1, 0, 4'd0, 4'd9, 0, 0, 0,   4'd0, 0, 0, 0, 4'd0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_mod_snap.md
Name: counter_mod_snap

Overview:
- Synchronous modulo-N up/down counter that consumes the latched bit stage and produces the user-visible count.
- Adds load, terminal-count pulse, sticky overflow and a valid/ready snapshot port, so a downstream consumer can sample the count without stalling it.
- Sits directly downstream of the per-bit storage stage in the 4-bit counter datapath.

Parameters:
- WIDTH, 4, counter width in bits.
- RESET_VAL, 0, count value after reset; must be <= every mod_val in use.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per enabled cycle.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  load load_val this cycle.
- load_val  input  WIDTH  value to load; clamped to mod_val.
- mod_val  input  WIDTH  terminal value; count range is 0..mod_val.
- q  output  WIDTH  current count.
- qn  output  WIDTH  bitwise complement of q; always consistent with q.
- tc  output  1  one-cycle terminal-count (wrap) pulse.
- ovf  output  1  sticky wrap flag.
- clr_ovf  input  1  clears ovf.
- snap_req  input  1  request capture of q.
- snap_valid  output  1  snapshot held.
- snap_ready  input  1  consumer accepts snapshot.
- snap_data  output  WIDTH  captured count.
- snap_miss  output  1  one-cycle pulse: snap_req dropped.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: q=RESET_VAL, qn=~RESET_VAL, tc=0, ovf=0, snap_valid=0, snap_data=0, snap_miss=0, FSM=SNAP_EMPTY.
- Reset asserted mid-operation discards any held snapshot and any pending wrap.
- Counter priority is reset > load > en. With none of these active, q holds and tc=0.
- Load: next q = min(load_val, mod_val). tc is not asserted on load, even if the loaded value is a terminal value.
- Up step:
  - q >= mod_val: next q = 0, tc=1.
  - Otherwise: next q = q+1.
  - The >= case covers mod_val lowered below q on the fly.
- Down step:
  - q == 0: next q = mod_val, tc=1.
  - q > mod_val: next q = mod_val, tc=0.
  - Otherwise: next q = q-1.
- mod_val=0: q stays 0 and tc=1 on every enabled cycle.
- Latency and arithmetic:
  - tc is registered and high in the same cycle the wrapped q first appears; 1-cycle latency from the enabled edge.
  - No arithmetic wider than WIDTH; the wrap decision uses compares only, never carry-out.
- ovf:
  - Set in the cycle after any cycle whose next-tc is 1.
  - Cleared the cycle after clr_ovf.
  - If set and clear coincide, set wins.
- Snapshot FSM has two states, SNAP_EMPTY and SNAP_FULL.
  - EMPTY & snap_req: snap_data <= current q (pre-update value of that cycle), go to FULL. snap_valid=1 from the next cycle.
  - FULL & snap_valid & snap_ready & !snap_req: go to EMPTY; snap_valid=0 next cycle.
  - FULL & snap_ready & snap_req: old snapshot transferred, new q captured, stay FULL. No bubble, no miss.
  - FULL & !snap_ready & snap_req: request dropped; snap_miss=1 next cycle; snap_data unchanged.
- snap_data and snap_valid are stable while snap_valid & !snap_ready.
- snap_ready is ignored in EMPTY.

Decomposition:
- Package counter_pkg holds:
  - typedef enum logic {SNAP_EMPTY, SNAP_FULL} snap_state_t;
  - localparam DIR_UP=1'b1 and DIR_DN=1'b0.
- One sub-module: count_snap_reg, containing the snapshot FSM, snap_data register and snap_miss generation.
- Counter and flag logic stay in the top module.

Test Plan:
- Reset-up wrap: reset then en=1, up_dn=1, mod_val=9 for 12 cycles -> q=0..9,0,1; tc=1 only when q=0 after 9; ovf=1 thereafter.
- Down wrap and load clamp:
  - load=1, load_val=12, mod_val=9 -> q=9.
  - Then up_dn=0 for 11 cycles -> q=8..0,9,8; tc=1 once, when q=9.
- On-the-fly mod change and mod_val=0:
  - q=7, set mod_val=4, up step -> q=0, tc=1.
  - Then mod_val=0 with en=1 for 3 cycles -> q=0 and tc=1 each cycle.
- Snapshot back-pressure:
  - snap_req at q=3 with snap_ready=0 -> snap_valid=1, snap_data=3.
  - snap_req at q=5 -> snap_miss pulse, snap_data stays 3.
  - snap_ready=1 -> snap_valid=0.
- Simultaneous accept and request: FULL with snap_data=2, snap_ready=1 and snap_req=1 at q=6 -> snap_valid stays 1, snap_data=6, no snap_miss.
- Flag and reset priority:
  - clr_ovf coinciding with a wrap -> ovf stays 1.
  - Synchronous reset while FULL and mid-count -> all outputs return to reset values next cycle; qn=~q throughout.
